// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        INIT    = 2'd0,
        RUN     = 2'd1,
        MD_BUSY = 2'd2
    } state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam int REG_W = 5;

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Operand forwarding select for one E-stage source register; M beats W.
module fwd_sel
    import hazard_pkg::*;
(
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] rd_m,
    input  logic [REG_W-1:0] rd_w,
    input  logic             regwrite_m,
    input  logic             regwrite_w,
    output logic [1:0]       fwd
);

    always_comb begin
        fwd = FWD_RF;
        if (regwrite_m && (rd_m != '0) && (rd_m == rs))
            fwd = FWD_MEM;
        else if (regwrite_w && (rd_w != '0) && (rd_w == rs))
            fwd = FWD_WB;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush/forward control for the 5-stage pipeline, with mul/div
// sequencing, post-reset fill and saturating performance counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MD_LAT      = 4,
    parameter int INIT_CYCLES = 3,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] Rs1D,
    input  logic [REG_W-1:0] Rs2D,
    input  logic [REG_W-1:0] Rs1E,
    input  logic [REG_W-1:0] Rs2E,
    input  logic [REG_W-1:0] RdE,
    input  logic [REG_W-1:0] RdM,
    input  logic [REG_W-1:0] RdW,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             ResultSrcE0,
    input  logic             PCSrcE,
    input  logic             MdStartE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             MdBusy,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt
);

    localparam int IW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam int MW = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    state_t        state, state_n;
    logic [IW-1:0] initcnt, initcnt_n;
    logic [MW-1:0] mdcnt, mdcnt_n;
    logic          lw_stall, md_stall, md_hold;
    logic [1:0]    fwd_a, fwd_b;

    fwd_sel u_fwd_a (
        .rs         (Rs1E),
        .rd_m       (RdM),
        .rd_w       (RdW),
        .regwrite_m (RegWriteM),
        .regwrite_w (RegWriteW),
        .fwd        (fwd_a)
    );

    fwd_sel u_fwd_b (
        .rs         (Rs2E),
        .rd_m       (RdM),
        .rd_w       (RdW),
        .regwrite_m (RegWriteM),
        .regwrite_w (RegWriteW),
        .fwd        (fwd_b)
    );

    always_comb begin
        lw_stall  = ResultSrcE0 && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
        md_stall  = MdStartE && (MD_LAT > 1);
        md_hold   = (mdcnt != MW'(1));

        state_n   = state;
        initcnt_n = initcnt;
        mdcnt_n   = mdcnt;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushM    = 1'b0;
        ForwardAE = fwd_a;
        ForwardBE = fwd_b;
        MdBusy    = (state == MD_BUSY);

        case (state)
            INIT: begin
                StallF = 1'b1;
                FlushD = 1'b1;
                FlushE = 1'b1;
                FlushM = 1'b1;
                if (initcnt == '0)
                    state_n = RUN;
                else
                    initcnt_n = initcnt - IW'(1);
            end
            RUN: begin
                StallF = lw_stall || md_stall;
                StallD = lw_stall || md_stall;
                StallE = md_stall;
                FlushM = md_stall;
                FlushD = PCSrcE;
                // A load-use bubble is only inserted when E is free to advance
                FlushE = PCSrcE || (lw_stall && !md_stall);
                if (md_stall) begin
                    mdcnt_n = MW'(MD_LAT - 1);
                    state_n = MD_BUSY;
                end
            end
            MD_BUSY: begin
                StallF  = md_hold;
                StallD  = md_hold;
                StallE  = md_hold;
                FlushM  = md_hold;
                mdcnt_n = mdcnt - MW'(1);
                if (!md_hold)
                    state_n = RUN;
            end
            default: state_n = INIT;
        endcase

        if (!reset) begin
            StallF    = 1'b1;
            StallD    = 1'b0;
            StallE    = 1'b0;
            FlushD    = 1'b1;
            FlushE    = 1'b1;
            FlushM    = 1'b1;
            ForwardAE = FWD_RF;
            ForwardBE = FWD_RF;
            MdBusy    = 1'b0;
        end
    end

    // Pipeline registers advance on negedge, so this state does too
    always_ff @(negedge clk) begin
        if (!reset) begin
            state    <= INIT;
            initcnt  <= IW'(INIT_CYCLES - 1);
            mdcnt    <= '0;
            StallCnt <= '0;
            FlushCnt <= '0;
        end else begin
            state   <= state_n;
            initcnt <= initcnt_n;
            mdcnt   <= mdcnt_n;
            if (StallF && (state != INIT))
                StallCnt <= sat_inc(StallCnt);
            if ((state == RUN) && PCSrcE)
                FlushCnt <= sat_inc(FlushCnt);
        end
    end

endmodule
